mem_fetch_arbiter: RTL



---
 rtl/mem_fetch_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_fetch_arbiter.sv
// Round-robin burst arbiter sharing one combinational-read memory port between
// the input-vector fetcher (req0) and the weight fetcher (req1).
// Optional feature: define MEM_ARB_PREEMPT_EN for MAX_BURST-beat grant slices.
module mem_fetch_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
`ifdef MEM_ARB_PREEMPT_EN
  , parameter int MAX_BURST = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic                  rd0_valid,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic                  rd0_last,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  rd1_last,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic [1:0][ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
  logic [1:0][LEN_WIDTH-1:0]  ctx_rem_q, ctx_rem_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [1:0]                 rd_valid_q, rd_valid_d;
  logic [1:0]                 rd_last_q, rd_last_d;
  logic [1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [1:0]                 req_valid;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][LEN_WIDTH-1:0]  req_len;
  logic [1:0]                 pending;
  logic                       pick;
  logic                       pick_valid;
  logic                       accept;
  logic [ADDR_WIDTH-1:0]      cur_addr;
  logic [LEN_WIDTH-1:0]       cur_rem;

`ifdef MEM_ARB_PREEMPT_EN
  localparam int SLICE_W = $clog2(MAX_BURST + 1);
  localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(MAX_BURST);

  logic [1:0]         susp_q, susp_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [SLICE_W-1:0] slice_next;
  logic               resume;
  logic               other_pending;
`endif

  assign req_valid = {req1_valid, req0_valid};
  assign req_addr  = {req1_addr, req0_addr};
  assign req_len   = {req1_len, req0_len};
  assign cur_addr  = ctx_addr_q[grant_q];
  assign cur_rem   = ctx_rem_q[grant_q];

`ifdef MEM_ARB_PREEMPT_EN
  // A suspended context competes like a live request but resumes without a handshake.
  assign pending       = req_valid | susp_q;
  assign resume        = pick_valid & susp_q[pick];
  assign accept        = pick_valid & ~resume;
  assign other_pending = req_valid[~grant_q] | susp_q[~grant_q];
  assign slice_next    = (slice_cnt_q == SLICE_MAX) ? slice_cnt_q : slice_cnt_q + 1'b1;
`else
  assign pending = req_valid;
  assign accept  = pick_valid;
`endif

  always_comb begin
    pick       = 1'b0;
    pick_valid = 1'b0;
    if (state_q == IDLE) begin
      if (pending[0] && pending[1]) begin
        pick       = ~last_grant_q;
        pick_valid = 1'b1;
      end else if (pending[0]) begin
        pick       = 1'b0;
        pick_valid = 1'b1;
      end else if (pending[1]) begin
        pick       = 1'b1;
        pick_valid = 1'b1;
      end
    end
  end

  // Ready is qualified by rst_n so the request side reads idle while reset is held.
  assign req0_ready = rst_n & accept & ~pick;
  assign req1_ready = rst_n & accept & pick;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ctx_addr_d   = ctx_addr_q;
    ctx_rem_d    = ctx_rem_q;
    mem_addr_d   = mem_addr_q;
    rd_valid_d   = 2'b00;
    rd_last_d    = 2'b00;
    rd_data_d    = rd_data_q;
`ifdef MEM_ARB_PREEMPT_EN
    susp_d       = susp_q;
    slice_cnt_d  = slice_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
`ifdef MEM_ARB_PREEMPT_EN
          slice_cnt_d  = '0;
          if (resume) begin
            susp_d[pick] = 1'b0;
            state_d      = BURST;
          end else
`endif
          begin
            ctx_addr_d[pick] = req_addr[pick];
            ctx_rem_d[pick]  = req_len[pick];
            if (req_len[pick] != '0) begin
              state_d = BURST;
            end
          end
        end
      end

      BURST: begin
        mem_addr_d             = cur_addr;
        ctx_addr_d[grant_q]    = cur_addr + 1'b1;
        ctx_rem_d[grant_q]     = cur_rem - 1'b1;
        rd_valid_d[grant_q]    = 1'b1;
        rd_data_d[grant_q]     = mem_data;
        rd_last_d[grant_q]     = (cur_rem == LEN_WIDTH'(1));
`ifdef MEM_ARB_PREEMPT_EN
        slice_cnt_d            = slice_next;
`endif
        if (cur_rem == LEN_WIDTH'(1)) begin
          state_d = IDLE;
        end
`ifdef MEM_ARB_PREEMPT_EN
        else if (slice_next == SLICE_MAX && other_pending) begin
          susp_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ctx_addr_q   <= '0;
      ctx_rem_q    <= '0;
      mem_addr_q   <= '0;
      rd_valid_q   <= 2'b00;
      rd_last_q    <= 2'b00;
      rd_data_q    <= '0;
`ifdef MEM_ARB_PREEMPT_EN
      susp_q       <= 2'b00;
      slice_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ctx_addr_q   <= ctx_addr_d;
      ctx_rem_q    <= ctx_rem_d;
      mem_addr_q   <= mem_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
`ifdef MEM_ARB_PREEMPT_EN
      susp_q       <= susp_d;
      slice_cnt_q  <= slice_cnt_d;
`endif
    end
  end

  // The live address comes straight from the context; the register only holds it across IDLE.
  assign mem_addr = (state_q == BURST) ? cur_addr : mem_addr_q;

  assign rd0_valid = rd_valid_q[0];
  assign rd1_valid = rd_valid_q[1];
  assign rd0_last  = rd_last_q[0];
  assign rd1_last  = rd_last_q[1];
  assign rd0_data  = rd_data_q[0];
  assign rd1_data  = rd_data_q[1];

`ifdef MEM_ARB_PREEMPT_EN
  assign busy = (state_q != IDLE) | (|rd_valid_q) | (|susp_q);
`else
  assign busy = (state_q != IDLE) | (|rd_valid_q);
`endif

endmodule
